// File: rtl/dsp_file_fifo.sv
// dsp_file_fifo: a bank of NUM_FILES independent 32-bit FIFOs ("files").
// The DSP engines use a level request / file_active handshake. The host
// wishbone glue pushes, pops and clears files whenever the DSP side is idle.
module dsp_file_fifo #(
  parameter int NUM_FILES  = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [7:0]  file_num,
  input  logic        file_read,
  input  logic        file_write,
  input  logic [31:0] file_write_data,
  output logic [31:0] file_read_data,
  output logic        file_active,
  output logic [31:0] rd_ptr,
  output logic [31:0] wr_ptr,
  input  logic [7:0]  host_file,
  input  logic        host_push,
  input  logic        host_pop,
  input  logic [31:0] host_data,
  input  logic        host_clear,
  output logic        host_ready,
  output logic [31:0] host_pop_data,
  output logic        host_pop_valid,
  output logic        overflow,
  output logic        underflow,
  output logic        bad_file,
  input  logic        host_clear_err
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int FW    = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  // Pointer helpers: the top bit is the wrap bit, the rest is the word index.
  function automatic logic ptr_empty(input logic [PW-1:0] rp, input logic [PW-1:0] wp);
    return rp == wp;
  endfunction

  function automatic logic ptr_full(input logic [PW-1:0] rp, input logic [PW-1:0] wp);
    return (rp[PW-2:0] == wp[PW-2:0]) && (rp[PW-1] != wp[PW-1]);
  endfunction

  logic [31:0]   mem [NUM_FILES][DEPTH];
  logic [PW-1:0] rd_ptr_q [NUM_FILES];
  logic [PW-1:0] rd_ptr_d [NUM_FILES];
  logic [PW-1:0] wr_ptr_q [NUM_FILES];
  logic [PW-1:0] wr_ptr_d [NUM_FILES];

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] acc_idx_q, acc_idx_d;
  logic          acc_ok_q, acc_ok_d;
  logic          file_active_q, file_active_d;
  logic [31:0]   file_read_data_q, file_read_data_d;
  logic [31:0]   host_pop_data_q, host_pop_data_d;
  logic          host_pop_valid_q, host_pop_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          bad_file_q, bad_file_d;
  logic          ovf_set, unf_set, bad_set;

  logic                  mem_we;
  logic [FW-1:0]         mem_wfile;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [31:0]           mem_wdata;

  logic          dsp_ok, host_ok;
  logic [FW-1:0] dsp_idx, host_idx;
  logic [PW-1:0] dsp_rp, dsp_wp, host_rp, host_wp, acc_rp, acc_wp;

  assign dsp_ok   = int'(file_num) < NUM_FILES;
  assign host_ok  = int'(host_file) < NUM_FILES;
  assign dsp_idx  = file_num[FW-1:0];
  assign host_idx = host_file[FW-1:0];
  assign dsp_rp   = rd_ptr_q[dsp_idx];
  assign dsp_wp   = wr_ptr_q[dsp_idx];
  assign host_rp  = rd_ptr_q[host_idx];
  assign host_wp  = wr_ptr_q[host_idx];
  assign acc_rp   = rd_ptr_q[acc_idx_q];
  assign acc_wp   = wr_ptr_q[acc_idx_q];

  assign host_ready     = (state_q == ST_IDLE) && !file_read && !file_write;
  assign rd_ptr         = dsp_ok ? 32'(dsp_rp) : 32'd0;
  assign wr_ptr         = dsp_ok ? 32'(dsp_wp) : 32'd0;
  assign file_active    = file_active_q;
  assign file_read_data = file_read_data_q;
  assign host_pop_data  = host_pop_data_q;
  assign host_pop_valid = host_pop_valid_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign bad_file       = bad_file_q;

  // Next-state for the DSP handshake FSM, host accesses, pointers and flags.
  always_comb begin
    state_d          = state_q;
    acc_idx_d        = acc_idx_q;
    acc_ok_d         = acc_ok_q;
    file_active_d    = file_active_q;
    file_read_data_d = file_read_data_q;
    host_pop_data_d  = host_pop_data_q;
    host_pop_valid_d = 1'b0;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    ovf_set          = 1'b0;
    unf_set          = 1'b0;
    bad_set          = 1'b0;
    mem_we           = 1'b0;
    mem_wfile        = dsp_idx;
    mem_widx         = dsp_wp[DEPTH_LOG2-1:0];
    mem_wdata        = file_write_data;

    case (state_q)
      ST_IDLE: begin
        if (file_read) begin
          state_d          = ST_RD;
          file_active_d    = 1'b1;
          acc_idx_d        = dsp_idx;
          acc_ok_d         = dsp_ok;
          file_read_data_d = 32'd0;
          if (!dsp_ok) bad_set = 1'b1;
          else if (ptr_empty(dsp_rp, dsp_wp)) unf_set = 1'b1;
          else file_read_data_d = mem[dsp_idx][dsp_rp[DEPTH_LOG2-1:0]];
        end else if (file_write) begin
          state_d       = ST_WR;
          file_active_d = 1'b1;
          acc_idx_d     = dsp_idx;
          acc_ok_d      = dsp_ok;
          if (!dsp_ok) bad_set = 1'b1;
          else if (ptr_full(dsp_rp, dsp_wp)) ovf_set = 1'b1;
          else mem_we = 1'b1;
        end else if (host_clear) begin
          if (!host_ok) bad_set = 1'b1;
          else begin
            rd_ptr_d[host_idx] = '0;
            wr_ptr_d[host_idx] = '0;
          end
        end else if (host_push) begin
          mem_wfile = host_idx;
          mem_widx  = host_wp[DEPTH_LOG2-1:0];
          mem_wdata = host_data;
          if (!host_ok) bad_set = 1'b1;
          else if (ptr_full(host_rp, host_wp)) ovf_set = 1'b1;
          else begin
            mem_we             = 1'b1;
            wr_ptr_d[host_idx] = host_wp + PW'(1);
          end
        end else if (host_pop) begin
          host_pop_valid_d = 1'b1;
          host_pop_data_d  = 32'd0;
          if (!host_ok) bad_set = 1'b1;
          else if (ptr_empty(host_rp, host_wp)) unf_set = 1'b1;
          else begin
            host_pop_data_d    = mem[host_idx][host_rp[DEPTH_LOG2-1:0]];
            rd_ptr_d[host_idx] = host_rp + PW'(1);
          end
        end
      end
      ST_RD: begin
        if (!file_read) begin
          state_d       = ST_IDLE;
          file_active_d = 1'b0;
          if (acc_ok_q && !ptr_empty(acc_rp, acc_wp))
            rd_ptr_d[acc_idx_q] = acc_rp + PW'(1);
        end
      end
      ST_WR: begin
        if (!file_write) begin
          state_d       = ST_IDLE;
          file_active_d = 1'b0;
          if (acc_ok_q && !ptr_full(acc_rp, acc_wp))
            wr_ptr_d[acc_idx_q] = acc_wp + PW'(1);
        end
      end
      default: begin
        state_d       = ST_IDLE;
        file_active_d = 1'b0;
      end
    endcase

    overflow_d  = (overflow_q  && !host_clear_err) || ovf_set;
    underflow_d = (underflow_q && !host_clear_err) || unf_set;
    bad_file_d  = (bad_file_q  && !host_clear_err) || bad_set;
  end

  // Control, pointer and output registers; everything returns to 0 on reset.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q          <= ST_IDLE;
      acc_idx_q        <= '0;
      acc_ok_q         <= 1'b0;
      file_active_q    <= 1'b0;
      file_read_data_q <= 32'd0;
      host_pop_data_q  <= 32'd0;
      host_pop_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      underflow_q      <= 1'b0;
      bad_file_q       <= 1'b0;
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      acc_idx_q        <= acc_idx_d;
      acc_ok_q         <= acc_ok_d;
      file_active_q    <= file_active_d;
      file_read_data_q <= file_read_data_d;
      host_pop_data_q  <= host_pop_data_d;
      host_pop_valid_q <= host_pop_valid_d;
      overflow_q       <= overflow_d;
      underflow_q      <= underflow_d;
      bad_file_q       <= bad_file_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
    end
  end

  // File storage: single write port shared by DSP writes and host pushes.
  always_ff @(posedge wb_clk) begin
    if (mem_we) mem[mem_wfile][mem_widx] <= mem_wdata;
  end
endmodule

// File: tb/tb_dsp_file_fifo.sv
// Directed bench for dsp_file_fifo: a vector table for single operations,
// then hand-written sequences for overflow, host/DSP contention, wrap-around
// and reset during an access.
module tb_dsp_file_fifo;
  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [7:0]  file_num = 8'd0;
  logic        file_read = 1'b0;
  logic        file_write = 1'b0;
  logic [31:0] file_write_data = 32'd0;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [31:0] rd_ptr, wr_ptr;
  logic [7:0]  host_file = 8'd0;
  logic        host_push = 1'b0;
  logic        host_pop = 1'b0;
  logic [31:0] host_data = 32'd0;
  logic        host_clear = 1'b0;
  logic        host_ready;
  logic [31:0] host_pop_data;
  logic        host_pop_valid;
  logic        overflow, underflow, bad_file;
  logic        host_clear_err = 1'b0;

  int checks = 0;
  int errors = 0;

  dsp_file_fifo #(.NUM_FILES(4), .DEPTH_LOG2(4)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .file_num(file_num), .file_read(file_read), .file_write(file_write),
    .file_write_data(file_write_data), .file_read_data(file_read_data),
    .file_active(file_active), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
    .host_file(host_file), .host_push(host_push), .host_pop(host_pop),
    .host_data(host_data), .host_clear(host_clear), .host_ready(host_ready),
    .host_pop_data(host_pop_data), .host_pop_valid(host_pop_valid),
    .overflow(overflow), .underflow(underflow), .bad_file(bad_file),
    .host_clear_err(host_clear_err)
  );

  always #5 wb_clk = ~wb_clk;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_CERR = 3'd5;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  file;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    logic [2:0]  exp_flags;   // {overflow, underflow, bad_file}
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] f, input logic [31:0] d);
    host_file = f; host_data = d; host_push = 1'b1;
    step();
    host_push = 1'b0;
  endtask

  task automatic do_pop(input logic [7:0] f, output logic [31:0] d, output logic v);
    host_file = f; host_pop = 1'b1;
    step();
    host_pop = 1'b0;
    d = host_pop_data;
    v = host_pop_valid;
  endtask

  task automatic do_clear(input logic [7:0] f);
    host_file = f; host_clear = 1'b1;
    step();
    host_clear = 1'b0;
  endtask

  task automatic do_clear_err();
    host_clear_err = 1'b1;
    step();
    host_clear_err = 1'b0;
  endtask

  // DSP access: raise the request, wait (bounded) for file_active, release.
  task automatic do_dsp(input logic is_read, input logic [7:0] f, input logic [31:0] wd,
                        output logic [31:0] rd);
    bit seen = 0;
    file_num = f; file_write_data = wd;
    if (is_read) file_read = 1'b1; else file_write = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (file_active) seen = 1;
    end
    rd = file_read_data;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL dsp_handshake: file_active never rose (file %0d)", f);
    end
    file_read = 1'b0; file_write = 1'b0;
    step();
    check("dsp_release_active", {31'd0, file_active}, 32'd0);
  endtask

  logic [31:0] d;
  logic        v;
  bit          accepted;

  initial begin
    // Single-operation vectors: op, file, din, exp_data, exp_rd, exp_wr, exp_flags
    vecs[0]  = '{OP_PUSH, 8'd0, 32'd3,          32'd0,          32'd0, 32'd1, 3'b000};
    vecs[1]  = '{OP_PUSH, 8'd0, 32'd5,          32'd0,          32'd0, 32'd2, 3'b000};
    vecs[2]  = '{OP_PUSH, 8'd0, 32'd7,          32'd0,          32'd0, 32'd3, 3'b000};
    vecs[3]  = '{OP_RD,   8'd0, 32'd0,          32'd3,          32'd1, 32'd3, 3'b000};
    vecs[4]  = '{OP_RD,   8'd0, 32'd0,          32'd5,          32'd2, 32'd3, 3'b000};
    vecs[5]  = '{OP_RD,   8'd0, 32'd0,          32'd7,          32'd3, 32'd3, 3'b000};
    vecs[6]  = '{OP_RD,   8'd2, 32'd0,          32'd0,          32'd0, 32'd0, 3'b010};
    vecs[7]  = '{OP_CERR, 8'd2, 32'd0,          32'd0,          32'd0, 32'd0, 3'b000};
    vecs[8]  = '{OP_RD,   8'd9, 32'd0,          32'd0,          32'd0, 32'd0, 3'b001};
    vecs[9]  = '{OP_CERR, 8'd9, 32'd0,          32'd0,          32'd0, 32'd0, 3'b000};
    vecs[10] = '{OP_WR,   8'd2, 32'hDEADBEEF,   32'd0,          32'd0, 32'd1, 3'b000};
    vecs[11] = '{OP_POP,  8'd2, 32'd0,          32'hDEADBEEF,   32'd1, 32'd1, 3'b000};
    vecs[12] = '{OP_POP,  8'd2, 32'd0,          32'd0,          32'd1, 32'd1, 3'b010};
    vecs[13] = '{OP_CLR,  8'd0, 32'd0,          32'd0,          32'd0, 32'd0, 3'b010};
    vecs[14] = '{OP_CERR, 8'd0, 32'd0,          32'd0,          32'd0, 32'd0, 3'b000};

    // Reset state
    repeat (2) step();
    check("rst_file_active", {31'd0, file_active}, 32'd0);
    check("rst_read_data", file_read_data, 32'd0);
    check("rst_rd_ptr", rd_ptr, 32'd0);
    check("rst_wr_ptr", wr_ptr, 32'd0);
    check("rst_flags", {29'd0, overflow, underflow, bad_file}, 32'd0);
    check("rst_pop_valid", {31'd0, host_pop_valid}, 32'd0);
    check("rst_pop_data", host_pop_data, 32'd0);
    wb_rst_n = 1'b1;
    step();
    check("host_ready_idle", {31'd0, host_ready}, 32'd1);

    // Table-driven single operations
    for (int i = 0; i < 15; i++) begin
      d = 32'd0; v = 1'b0;
      case (vecs[i].op)
        OP_PUSH: do_push(vecs[i].file, vecs[i].din);
        OP_POP:  do_pop(vecs[i].file, d, v);
        OP_RD:   do_dsp(1'b1, vecs[i].file, 32'd0, d);
        OP_WR:   do_dsp(1'b0, vecs[i].file, vecs[i].din, d);
        OP_CLR:  do_clear(vecs[i].file);
        default: do_clear_err();
      endcase
      file_num = vecs[i].file;
      #1;
      if (vecs[i].op == OP_RD || vecs[i].op == OP_POP)
        check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      if (vecs[i].op == OP_POP)
        check($sformatf("vec%0d_pop_valid", i), {31'd0, v}, 32'd1);
      check($sformatf("vec%0d_rd_ptr", i), rd_ptr, vecs[i].exp_rd);
      check($sformatf("vec%0d_wr_ptr", i), wr_ptr, vecs[i].exp_wr);
      check($sformatf("vec%0d_flags", i), {29'd0, overflow, underflow, bad_file},
            {29'd0, vecs[i].exp_flags});
    end
    step();
    check("pop_valid_pulse", {31'd0, host_pop_valid}, 32'd0);

    // Fill file 1, then overflow with a 17th word
    for (int i = 0; i < 16; i++) do_push(8'd1, 32'd100 + 32'(i));
    file_num = 8'd1; #1;
    check("fill_wr_ptr", wr_ptr, 32'd16);
    check("fill_no_ovf", {31'd0, overflow}, 32'd0);
    do_push(8'd1, 32'd999);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_wr_ptr", wr_ptr, 32'd16);
    for (int i = 0; i < 16; i++) begin
      do_pop(8'd1, d, v);
      check($sformatf("drain1_%0d", i), d, 32'd100 + 32'(i));
    end
    check("drain1_rd_ptr", rd_ptr, 32'd16);
    check("drain1_no_unf", {31'd0, underflow}, 32'd0);
    do_clear_err();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // DSP write on file 3 holds off a simultaneous host push
    file_num = 8'd3; file_write_data = 32'h1111; file_write = 1'b1;
    host_file = 8'd3; host_data = 32'd77; host_push = 1'b1;
    repeat (3) begin
      step();
      check("contend_active", {31'd0, file_active}, 32'd1);
      check("contend_ready", {31'd0, host_ready}, 32'd0);
    end
    file_write = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      @(negedge wb_clk);
      if (host_ready) accepted = 1;
      step();
    end
    host_push = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL contend_retry: host_ready never returned");
    end
    check("contend_wr_ptr", wr_ptr, 32'd2);
    do_pop(8'd3, d, v);
    check("contend_pop0", d, 32'h1111);
    do_pop(8'd3, d, v);
    check("contend_pop1", d, 32'd77);

    // 40 push/pop pairs on file 3 from a cleared file: two pointer wraps
    do_clear(8'd3);
    check("clr3_rd_ptr", rd_ptr, 32'd0);
    for (int i = 0; i < 40; i++) begin
      do_push(8'd3, 32'h3000 + 32'(i * 3));
      do_pop(8'd3, d, v);
      check($sformatf("wrap_%0d", i), d, 32'h3000 + 32'(i * 3));
    end
    check("wrap_rd_ptr", rd_ptr, 32'd8);
    check("wrap_wr_ptr", wr_ptr, 32'd8);
    check("wrap_flags", {29'd0, overflow, underflow, bad_file}, 32'd0);

    // Reset in the middle of a DSP read
    do_push(8'd3, 32'h55);
    file_num = 8'd3; file_read = 1'b1;
    step();
    step();
    check("pre_rst_active", {31'd0, file_active}, 32'd1);
    #2 wb_rst_n = 1'b0;
    #1;
    check("mid_rst_active", {31'd0, file_active}, 32'd0);
    check("mid_rst_wr_ptr", wr_ptr, 32'd0);
    check("mid_rst_rd_ptr", rd_ptr, 32'd0);
    file_read = 1'b0;
    step();
    wb_rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, host_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
